// File: rtl/switch_pkg.sv
// Shared switch-fabric types: port masks, the demux ingress states, and the one-hot test.
package switch_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [NUM_PORTS-1:0] port_mask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } demux_state_t;

    // Zero and multi-hot both fail, matching the select mux's default case.
    function automatic logic is_onehot(port_mask_t m);
        return (m != '0) && ((m & (m - port_mask_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/frame_demux_out_stage.sv
// Single-entry egress register shared by all ports, with per-port pending tracking.
// FRAME_DEMUX_BCAST_EN keeps a separate pending mask so multicast beats retire port by port.
module frame_demux_out_stage
    import switch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_data_i,
    input  logic                 load_last_i,
    input  logic [NUM_PORTS-1:0] load_mask_i,
    input  logic [NUM_PORTS-1:0] out_ready_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_last_o,
    output logic [NUM_PORTS-1:0] out_valid_o,
    output logic                 busy_o,
    output logic                 drain_o
);

    logic                 vld_q, vld_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 last_q, last_d;
    port_mask_t           sel_q, sel_d;
    port_mask_t           pending;
    port_mask_t           hs;
    port_mask_t           remaining;

`ifdef FRAME_DEMUX_BCAST_EN
    port_mask_t           pend_q, pend_d;
    assign pending = pend_q;
`else
    // With one-hot masks the beat's own mask is all that is ever outstanding.
    assign pending = sel_q;
`endif

    assign out_valid_o = vld_q ? (sel_q & pending) : '0;
    assign hs          = out_valid_o & out_ready_i;
    assign remaining   = pending & ~hs;
    assign drain_o     = vld_q && (remaining == '0);
    assign busy_o      = vld_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        sel_d  = sel_q;
`ifdef FRAME_DEMUX_BCAST_EN
        pend_d = remaining;
`endif
        if (load_i) begin
            vld_d  = 1'b1;
            data_d = load_data_i;
            last_d = load_last_i;
            sel_d  = load_mask_i;
`ifdef FRAME_DEMUX_BCAST_EN
            pend_d = load_mask_i;
`endif
        end else if (drain_o) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            sel_q  <= '0;
`ifdef FRAME_DEMUX_BCAST_EN
            pend_q <= '0;
`endif
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            sel_q  <= sel_d;
`ifdef FRAME_DEMUX_BCAST_EN
            pend_q <= pend_d;
`endif
        end
    end

endmodule

// File: rtl/frame_demux4.sv
// Frame-aware 1:4 demux: the first beat's mask steers the whole frame; bad masks drop the frame.
// FRAME_DEMUX_BCAST_EN accepts any non-zero mask (multicast) instead of one-hot only.
module frame_demux4
    import switch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [3:0]       in_dest,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    demux_state_t     state_q;
    port_mask_t       frame_mask_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic             busy;
    logic             drain;
    logic             accept;
    logic             mask_ok;
    logic             load;
    port_mask_t       load_mask;

`ifdef FRAME_DEMUX_BCAST_EN
    assign mask_ok = (in_dest != '0);
`else
    assign mask_ok = is_onehot(in_dest);
`endif

    assign in_ready  = (state_q == DROP) || !busy || drain;
    assign accept    = in_valid && in_ready;
    assign load      = accept && (((state_q == IDLE) && mask_ok) || (state_q == FWD));
    assign load_mask = (state_q == FWD) ? frame_mask_q : in_dest;
    assign drop_cnt  = drop_cnt_q;

    frame_demux_out_stage #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_data_i (in_data),
        .load_last_i (in_last),
        .load_mask_i (load_mask),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .busy_o      (busy),
        .drain_o     (drain)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_mask_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (mask_ok) begin
                            frame_mask_q <= in_dest;
                            state_q      <= in_last ? IDLE : FWD;
                        end else begin
                            if (drop_cnt_q != {CNT_W{1'b1}})
                                drop_cnt_q <= drop_cnt_q + 1'b1;
                            state_q <= in_last ? IDLE : DROP;
                        end
                    end
                end
                FWD: begin
                    if (accept && in_last)
                        state_q <= IDLE;
                end
                DROP: begin
                    if (accept && in_last)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_demux4.sv
// Directed bench for frame_demux4 (CNT_W=4 so counter saturation is reachable quickly).
module tb_frame_demux4;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef FRAME_DEMUX_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic [3:0]       in_dest;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_drop = 0;

    frame_demux4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic [3:0] m);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_dest  = m;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] v, input logic [WIDTH-1:0] d, input logic l);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".last"},  32'(out_last),  32'(l));
    endtask

    task automatic bump_drop();
        if (exp_drop < 15) exp_drop++;
    endtask

    initial begin
        rst = 1'b1; out_ready = 4'hF;
        drive(1'b0, 8'h00, 1'b0, 4'h0);
        tick(); tick();
        chk_out("reset", 4'h0, 8'h00, 1'b0);
        chk("reset.drop", 32'(drop_cnt), 0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 1);

        // 3-beat frame to port 2
        drive(1'b1, 8'hA1, 1'b0, 4'b0100);
        chk("t1.rdy0", 32'(in_ready), 1);
        tick();
        chk_out("t1.b1", 4'b0100, 8'hA1, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, 4'b0000);
        chk("t1.rdy1", 32'(in_ready), 1);
        tick();
        chk_out("t1.b2", 4'b0100, 8'hA2, 1'b0);
        drive(1'b1, 8'hA3, 1'b1, 4'b0001);
        tick();
        chk_out("t1.b3", 4'b0100, 8'hA3, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'h0);
        tick();
        chk("t1.idle", 32'(out_valid), 0);
        chk("t1.drop", 32'(drop_cnt), 0);

        // back-to-back frames, port 0 then port 3
        drive(1'b1, 8'hB1, 1'b0, 4'b0001); tick();
        chk_out("t2.b1", 4'b0001, 8'hB1, 1'b0);
        drive(1'b1, 8'hB2, 1'b1, 4'b0000); tick();
        chk_out("t2.b2", 4'b0001, 8'hB2, 1'b1);
        drive(1'b1, 8'hC1, 1'b0, 4'b1000);
        chk("t2.rdy", 32'(in_ready), 1);
        tick();
        chk_out("t2.c1", 4'b1000, 8'hC1, 1'b0);
        drive(1'b1, 8'hC2, 1'b1, 4'b0000); tick();
        chk_out("t2.c2", 4'b1000, 8'hC2, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'h0); tick();
        chk("t2.idle", 32'(out_valid), 0);

        // zero mask frame always drops
        drive(1'b1, 8'hD1, 1'b0, 4'b0000);
        chk("t3.rdy0", 32'(in_ready), 1);
        tick(); bump_drop();
        chk("t3.v0", 32'(out_valid), 0);
        drive(1'b1, 8'hD2, 1'b1, 4'b0100);
        chk("t3.rdy1", 32'(in_ready), 1);
        tick();
        chk("t3.v1", 32'(out_valid), 0);
        // multi-hot frame: dropped unless multicast is enabled
        drive(1'b1, 8'hE1, 1'b0, 4'b0011);
        chk("t3.rdy2", 32'(in_ready), 1);
        tick();
        if (!BCAST) bump_drop();
        chk_out("t3.e1", BCAST ? 4'b0011 : 4'b0000, BCAST ? 8'hE1 : 8'hC2, BCAST ? 1'b0 : 1'b1);
        drive(1'b1, 8'hE2, 1'b1, 4'b0000);
        chk("t3.rdy3", 32'(in_ready), 1);
        tick();
        chk("t3.v3", 32'(out_valid), BCAST ? 4'b0011 : 4'b0000);
        drive(1'b0, 8'h00, 1'b0, 4'h0); tick();
        chk("t3.drop", 32'(drop_cnt), 32'(exp_drop));

        // backpressure on port 1 for 5 cycles
        out_ready = 4'b1101;
        drive(1'b1, 8'hF1, 1'b0, 4'b0010); tick();
        chk_out("t4.f1", 4'b0010, 8'hF1, 1'b0);
        drive(1'b1, 8'hF2, 1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk("t4.stall_rdy", 32'(in_ready), 0);
            tick();
            chk_out("t4.hold", 4'b0010, 8'hF1, 1'b0);
        end
        chk("t4.stall_rdy", 32'(in_ready), 0);
        out_ready = 4'hF;
        #1;
        chk("t4.release_rdy", 32'(in_ready), 1);
        tick();
        chk_out("t4.f2", 4'b0010, 8'hF2, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'h0); tick();
        chk("t4.idle", 32'(out_valid), 0);

        // mask 1010: multicast with a late port 3, or a drop otherwise
        if (BCAST) begin
            out_ready = 4'b0010;
            drive(1'b1, 8'h61, 1'b0, 4'b1010); tick();
            chk_out("t5.g1", 4'b1010, 8'h61, 1'b0);
            drive(1'b1, 8'h62, 1'b0, 4'b0000);
            chk("t5.rdy0", 32'(in_ready), 0);
            tick();
            chk_out("t5.part", 4'b1000, 8'h61, 1'b0);
            chk("t5.rdy1", 32'(in_ready), 0);
            tick();
            chk_out("t5.part2", 4'b1000, 8'h61, 1'b0);
            out_ready = 4'b1010;
            #1;
            chk("t5.rdy2", 32'(in_ready), 1);
            tick();
            chk_out("t5.g2", 4'b1010, 8'h62, 1'b0);
        end else begin
            drive(1'b1, 8'h61, 1'b0, 4'b1010);
            chk("t5.rdy0", 32'(in_ready), 1);
            tick(); bump_drop();
            chk("t5.v0", 32'(out_valid), 0);
            chk("t5.drop", 32'(drop_cnt), 32'(exp_drop));
            drive(1'b1, 8'h62, 1'b0, 4'b0010); tick();
            chk("t5.v1", 32'(out_valid), 0);
        end
        // reset in the middle of the frame
        drive(1'b0, 8'h00, 1'b0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_drop = 0;
        chk_out("t5.rst", 4'h0, 8'h00, 1'b0);
        chk("t5.rst_drop", 32'(drop_cnt), 0);
        out_ready = 4'hF;
        drive(1'b1, 8'h71, 1'b1, 4'b0100);
        chk("t5.rst_rdy", 32'(in_ready), 1);
        tick();
        chk_out("t5.first", 4'b0100, 8'h71, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'h0); tick();

        // 16 single-beat invalid frames saturate the counter
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 4'b0000);
            tick(); bump_drop();
            chk("t6.drop", 32'(drop_cnt), 32'(exp_drop));
        end
        chk("t6.sat", 32'(drop_cnt), 32'hF);
        drive(1'b1, 8'h81, 1'b1, 4'b0001); tick();
        chk_out("t6.after", 4'b0001, 8'h81, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'h0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
